// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32IM pipeline stage registers: bubble encoding,
// skid-buffer state type, counter width default and per-stage payload layouts.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'h00000013;
    localparam int          STALL_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second entry and EMPTY/ONE/TWO state machine for the skid-mode stage register.
// Tells the parent when to load its main entry and from where; state is readable as u_skid.state.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              out_valid,
    output logic              load_in,
    output logic              load_skid,
    output logic              clear_main,
    output logic [DATA_W-1:0] skid_data
);

    skid_state_e state, state_nxt;
    logic        skid_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       skid_data <= '0;
        else if (skid_we) skid_data <= in_data;
    end

    // Both handshake outputs decode only the state register, so neither input side sees a comb path.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);

    always_comb begin
        state_nxt  = state;
        load_in    = 1'b0;
        load_skid  = 1'b0;
        clear_main = 1'b0;
        skid_we    = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_valid) begin
                    state_nxt = ONE;
                    load_in   = 1'b1;
                end
                ONE: begin
                    if (out_ready && in_valid) begin
                        load_in = 1'b1;
                    end else if (out_ready) begin
                        state_nxt  = EMPTY;
                        clear_main = 1'b1;
                    end else if (in_valid) begin
                        state_nxt = TWO;
                        skid_we   = 1'b1;
                    end
                end
                TWO: if (out_ready) begin
                    state_nxt = ONE;
                    load_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid build with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL  = DATA_W'(NOP_INSTR),
    parameter int                STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // Handshake: a beat moves on a rising edge where valid && ready; flush overrides both sides.
    logic              load_in;
    logic              load_skid;
    logic              clear_main;
    logic [DATA_W-1:0] skid_data;

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .load_in   (load_in),
        .load_skid (load_skid),
        .clear_main(clear_main),
        .skid_data (skid_data)
    );
`else
    logic out_valid_q;
    logic accept;
    logic drain;

    assign in_ready   = !out_valid_q || out_ready;
    assign out_valid  = out_valid_q;
    assign accept     = in_valid && in_ready && !flush;
    assign drain      = out_valid_q && out_ready;
    assign load_in    = accept;
    assign load_skid  = 1'b0;
    assign clear_main = drain && !accept;
    assign skid_data  = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      out_valid_q <= 1'b0;
        else if (flush)  out_valid_q <= 1'b0;
        else if (accept) out_valid_q <= 1'b1;
        else if (drain)  out_valid_q <= 1'b0;
    end
`endif

    // Main entry: holds the bubble whenever nothing valid is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          out_data <= BUBBLE_VAL;
        else if (flush)      out_data <= BUBBLE_VAL;
        else if (load_in)    out_data <= in_data;
        else if (load_skid)  out_data <= skid_data;
        else if (clear_main) out_data <= BUBBLE_VAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (out_valid && !out_ready && !flush && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg in either build; compares against a queue model of held beats.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam logic [31:0] BUBBLE = 32'h00000013;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] stall_cycles;

    logic        s_flush = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [31:0] s_in_data = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [31:0] s_out_data;
    logic [3:0]  s_stall_cycles;

    logic [31:0] exp_q[$];
    logic [15:0] exp_stall = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(32'h00000013)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cycles(stall_cycles)
    );

    pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(32'h00000013), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_cycles(s_stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model at posedge.
    task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                        output bit acc);
        bit exp_ready;
        int held;
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
        #1;
        held      = exp_q.size();
        exp_ready = (CAP == 2) ? (held < 2) : (held == 0 || ordy);
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        check("out_valid", {31'b0, out_valid}, {31'b0, held != 0});
        check("out_data", out_data, (held != 0) ? exp_q[0] : BUBBLE);
        check("stall_cycles", {16'b0, stall_cycles}, {16'b0, exp_stall});
        @(posedge clk);
        acc = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (held != 0 && ordy) void'(exp_q.pop_front());
            if (iv && exp_ready) begin
                exp_q.push_back(id);
                acc = 1'b1;
            end
        end
        if (held != 0 && !ordy && !fl && exp_stall != 16'hFFFF) exp_stall++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, BUBBLE);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_stall", {16'b0, stall_cycles}, 32'd0);
        exp_q.delete();
        exp_stall = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        bit got_a5;
        bit got_5a;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill the stage then pull reset asynchronously mid-stream.
        step(1'b1, 32'h100, 1'b0, 1'b0, acc);
        step(1'b1, 32'h101, 1'b0, 1'b0, acc);
        step(1'b1, 32'h102, 1'b0, 1'b0, acc);
        do_reset();

        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0, acc);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Back-pressure with two offered beats.
        do_reset();
        step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, got_a5);
        got_5a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(!got_5a, 32'h5A5A5A5A, 1'b0, 1'b0, acc);
            got_5a |= acc;
        end
        #1;
        check("bp_accept_a5", {31'b0, got_a5}, 32'd1);
        check("bp_stall", {16'b0, stall_cycles}, 32'd5);
        check("bp_hold", out_data, 32'hA5A5A5A5);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 10 && (exp_q.size() != 0 || !got_5a); i++) begin
            step(!got_5a, 32'h5A5A5A5A, 1'b1, 1'b0, acc);
            got_5a |= acc;
        end
        check("bp_5a_delivered", {31'b0, got_5a && exp_q.size() == 0}, 32'd1);

        // Flush while holding a beat and offering another.
        step(1'b1, 32'h11, 1'b0, 1'b0, acc);
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, acc);
        #1;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_data", out_data, BUBBLE);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Drain and accept together with one beat held.
        step(1'b1, 32'h77, 1'b0, 1'b0, acc);
        step(1'b1, 32'h88, 1'b1, 1'b0, acc);
        #1;
        check("da_data", out_data, 32'h88);
        check("da_valid", {31'b0, out_valid}, 32'd1);
        check("da_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef PIPE_STAGE_SKID_EN
        check("da_state", {30'b0, dut.u_skid.state}, {30'b0, ONE});
`endif
        step(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, acc);
        end
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Saturation on the 4-bit counter instance.
        @(negedge clk);
        s_in_valid = 1'b1; s_in_data = 32'hCAFE0001; s_out_ready = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b0;
        check("sat_valid", {31'b0, s_out_valid}, 32'd1);
        check("sat_data", s_out_data, 32'hCAFE0001);
        repeat (12) @(negedge clk);
        check("sat_mid", {28'b0, s_stall_cycles}, 32'd12);
        repeat (8) @(negedge clk);
        check("sat_full", {28'b0, s_stall_cycles}, 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
